// File: rtl/vga_timing_gen.sv
// VGA raster generator (640x480@60 by default): pixel position, blanking, syncs, strobes, frame counter.
// Optional macro VGA_PIPE_ALIGN_EN delays hs/vs by one vga_clk to match sprite blocks that register colour.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Totals must not exceed 1024 so the counters fit in 10 bits; window bounds use 11 bits
  // so an end bound equal to 1024 is still representable.
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  hc, vc;
  logic [9:0]  hc_next, vc_next;
  logic [10:0] hc_wide, vc_wide;
  logic        frame_wrap;
  logic        hs_raw, vs_raw;

  always_comb begin
    hc_next    = hc + 10'd1;
    vc_next    = vc;
    frame_wrap = 1'b0;
    if (hc == H_LAST) begin
      hc_next = '0;
      if (vc == V_LAST) begin
        vc_next    = '0;
        frame_wrap = 1'b1;
      end else begin
        vc_next = vc + 10'd1;
      end
    end
  end

  assign hc_wide = {1'b0, hc_next};
  assign vc_wide = {1'b0, vc_next};

  // Outputs are decoded from the next position so they line up with the registered counters.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b1;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      frame_count <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      blank       <= (hc_wide < H_VIS) && (vc_wide < V_VIS);
      hs_raw      <= !((hc_wide >= HS_BEGIN) && (hc_wide < HS_END));
      vs_raw      <= !((vc_wide >= VS_BEGIN) && (vc_wide < VS_END));
      line_start  <= (hc_next == 10'd0);
      frame_start <= (hc_next == 10'd0) && (vc_next == 10'd0);
      if (frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_dly, vs_dly;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_dly <= 1'b1;
      vs_dly <= 1'b1;
    end else begin
      hs_dly <= hs_raw;
      vs_dly <= vs_raw;
    end
  end

  assign hs = hs_dly;
  assign vs = vs_dly;
`else
  assign hs = hs_raw;
  assign vs = vs_raw;
`endif

endmodule
